// File: rtl/secure_vault_ctrl.sv
// Password vault controller: master-password authentication with lockout, per-address tweaked
// XOR encryption of stored entries, an entry-valid map and idle auto-relock.
module secure_vault_ctrl #(
   parameter int unsigned       DATA_W         = 8,
   parameter int unsigned       DEPTH          = 16,
   parameter int unsigned       ADDR_W         = 4,
   parameter logic [DATA_W-1:0] MASTER_PASS    = 8'hA5,
   parameter logic [DATA_W-1:0] TWEAK_MUL      = 8'h1D,
   parameter int unsigned       MAX_FAILS      = 3,
   parameter int unsigned       LOCKOUT_CYCLES = 64,
   parameter int unsigned       IDLE_TIMEOUT   = 256
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               auth_valid,
   input  logic [DATA_W-1:0]                  auth_pass,
   output logic                               auth_ack,
   output logic                               auth_nack,
   input  logic                               lock_req,
   input  logic                               wr_valid,
   input  logic [ADDR_W-1:0]                  wr_addr,
   input  logic [DATA_W-1:0]                  wr_data,
   output logic [DATA_W-1:0]                  wr_cipher,
   input  logic                               rd_valid,
   input  logic [ADDR_W-1:0]                  rd_addr,
   output logic [DATA_W-1:0]                  rd_data,
   output logic                               rd_data_valid,
   output logic                               rd_miss,
   output logic                               acc_denied,
   output logic                               unlocked,
   output logic                               locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

   localparam int unsigned FailW  = $clog2(MAX_FAILS + 1);
   localparam int unsigned TmrMax = (LOCKOUT_CYCLES > IDLE_TIMEOUT) ? LOCKOUT_CYCLES
                                                                    : IDLE_TIMEOUT;
   localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

   localparam logic [TmrW-1:0]   LockLoad = TmrW'(LOCKOUT_CYCLES - 1);
   localparam logic [TmrW-1:0]   IdleLoad = TmrW'(IDLE_TIMEOUT - 1);
   localparam logic [FailW-1:0]  FailMax  = FailW'(MAX_FAILS);
   localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      StLocked   = 2'd0,
      StUnlocked = 2'd1,
      StLockout  = 2'd2
   } state_e;

   // Tweak is taken modulo 2^DATA_W, so truncating the address first is harmless.
   function automatic logic [DATA_W-1:0] tweak(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) * TWEAK_MUL;
   endfunction

   state_e              state_q, state_d;
   logic [FailW-1:0]    fail_q, fail_d, fail_inc;
   logic [TmrW-1:0]     timer_q, timer_d;
   logic                auth_ack_q, auth_ack_d;
   logic                auth_nack_q, auth_nack_d;
   logic                relock;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [DATA_W-1:0]   wr_cipher_q, wr_cipher_d;
   logic [DATA_W-1:0]   rd_data_q, rd_plain;
   logic                rd_data_valid_q, rd_miss_q, acc_denied_q;

   logic                pass_ok, access_ok, wr_in_range, rd_in_range;
   logic                wr_acc, rd_acc, rd_hit, deny;

   assign pass_ok     = (auth_pass == MASTER_PASS);
   assign fail_inc    = fail_q + 1'b1;

   // lock_req in the same cycle as an access wins, so the access is refused.
   assign access_ok   = (state_q == StUnlocked) && !lock_req;
   assign wr_in_range = ({1'b0, wr_addr} < DepthLim);
   assign rd_in_range = ({1'b0, rd_addr} < DepthLim);
   assign wr_acc      = wr_valid && access_ok && wr_in_range;
   assign rd_acc      = rd_valid && access_ok && rd_in_range;
   assign deny        = (wr_valid && !wr_acc) || (rd_valid && !rd_acc);

   assign wr_cipher_d = wr_data ^ MASTER_PASS ^ tweak(wr_addr);
   assign rd_hit      = valid_q[rd_addr];
   assign rd_plain    = mem_q[rd_addr] ^ MASTER_PASS ^ tweak(rd_addr);

   always_comb begin
      state_d     = state_q;
      fail_d      = fail_q;
      timer_d     = timer_q;
      auth_ack_d  = 1'b0;
      auth_nack_d = 1'b0;
      relock      = 1'b0;
      case (state_q)
         StLocked: begin
            if (auth_valid) begin
               if (pass_ok) begin
                  auth_ack_d = 1'b1;
                  state_d    = StUnlocked;
                  fail_d     = '0;
                  timer_d    = IdleLoad;
               end else begin
                  auth_nack_d = 1'b1;
                  fail_d      = fail_inc;
                  if (fail_inc == FailMax) begin
                     state_d = StLockout;
                     timer_d = LockLoad;
                  end
               end
            end
         end
         StLockout: begin
            auth_nack_d = auth_valid;
            if (timer_q == '0) begin
               state_d = StLocked;
               fail_d  = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StUnlocked: begin
            auth_ack_d  = auth_valid && pass_ok;
            auth_nack_d = auth_valid && !pass_ok;
            if (lock_req) begin
               state_d = StLocked;
               relock  = 1'b1;
            end else if (rd_acc || wr_acc) begin
               timer_d = IdleLoad;
            end else if (timer_q == '0) begin
               state_d = StLocked;
               relock  = 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = StLocked;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StLocked;
         fail_q          <= '0;
         timer_q         <= '0;
         auth_ack_q      <= 1'b0;
         auth_nack_q     <= 1'b0;
         valid_q         <= '0;
         wr_cipher_q     <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
         rd_miss_q       <= 1'b0;
         acc_denied_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         fail_q          <= fail_d;
         timer_q         <= timer_d;
         auth_ack_q      <= auth_ack_d;
         auth_nack_q     <= auth_nack_d;
         acc_denied_q    <= deny;
         rd_data_valid_q <= rd_acc && rd_hit;
         rd_miss_q       <= rd_acc && !rd_hit;
         // Relock and an accepted read never coincide, so the order here is free.
         if (rd_acc) begin
            rd_data_q <= rd_hit ? rd_plain : '0;
         end else if (relock) begin
            rd_data_q <= '0;
         end
         if (wr_acc) begin
            valid_q[wr_addr] <= 1'b1;
            wr_cipher_q      <= wr_cipher_d;
         end
      end
   end

   // Storage needs no reset: an entry is only readable once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_addr] <= wr_cipher_d;
      end
   end

   assign auth_ack      = auth_ack_q;
   assign auth_nack     = auth_nack_q;
   assign wr_cipher     = wr_cipher_q;
   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_miss       = rd_miss_q;
   assign acc_denied    = acc_denied_q;
   assign unlocked      = (state_q == StUnlocked);
   assign locked_out    = (state_q == StLockout);
   assign fail_count    = fail_q;

endmodule

// File: tb/tb_secure_vault_ctrl.sv
// Bench for secure_vault_ctrl: directed scenarios plus random traffic, all compared each cycle
// against a deadline-based behavioural model of the vault.
module tb_secure_vault_ctrl;

   localparam int          DATA_W         = 8;
   localparam int          DEPTH          = 16;
   localparam int          ADDR_W         = 4;
   localparam int          MAX_FAILS      = 3;
   localparam int          LOCKOUT_CYCLES = 64;
   localparam int          IDLE_TIMEOUT   = 256;
   localparam logic [7:0]  KEY            = 8'hA5;
   localparam int          MUL            = 29;
   localparam int          M_LOCKED = 0, M_UNL = 1, M_LO = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              auth_valid = 1'b0;
   logic [7:0]        auth_pass = '0;
   logic              auth_ack, auth_nack;
   logic              lock_req = 1'b0;
   logic              wr_valid = 1'b0;
   logic [3:0]        wr_addr = '0;
   logic [7:0]        wr_data = '0;
   logic [7:0]        wr_cipher;
   logic              rd_valid = 1'b0;
   logic [3:0]        rd_addr = '0;
   logic [7:0]        rd_data;
   logic              rd_data_valid, rd_miss, acc_denied, unlocked, locked_out;
   logic [1:0]        fail_count;

   secure_vault_ctrl #(
      .DATA_W         (DATA_W),
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .MASTER_PASS    (8'hA5),
      .TWEAK_MUL      (8'h1D),
      .MAX_FAILS      (MAX_FAILS),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .IDLE_TIMEOUT   (IDLE_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .auth_valid    (auth_valid),
      .auth_pass     (auth_pass),
      .auth_ack      (auth_ack),
      .auth_nack     (auth_nack),
      .lock_req      (lock_req),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_cipher     (wr_cipher),
      .rd_valid      (rd_valid),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .rd_miss       (rd_miss),
      .acc_denied    (acc_denied),
      .unlocked      (unlocked),
      .locked_out    (locked_out),
      .fail_count    (fail_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: mode plus absolute deadlines instead of down-counters; entries kept as plaintext.
   int         cyc = 0;
   int         m_mode, m_fails, m_last_act, m_lock_start;
   logic [7:0] m_plain [DEPTH];
   bit         m_valid [DEPTH];
   logic       exp_ack, exp_nack, exp_rdv, exp_miss, exp_denied;
   logic [7:0] exp_rd_data, exp_cipher;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_LOCKED;
      m_fails = 0;
      m_last_act = 0;
      m_lock_start = 0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      exp_ack = 0; exp_nack = 0; exp_rdv = 0; exp_miss = 0; exp_denied = 0;
      exp_rd_data = '0;
      exp_cipher = '0;
   endtask

   task automatic model_step();
      int   mode0;
      bit   racc, wacc, relock;
      int   ra, wa;
      cyc++;
      mode0  = m_mode;
      relock = 0;
      ra = int'(rd_addr);
      wa = int'(wr_addr);
      racc = rd_valid && mode0 == M_UNL && !lock_req && ra < DEPTH;
      wacc = wr_valid && mode0 == M_UNL && !lock_req && wa < DEPTH;
      exp_denied = (rd_valid && !racc) || (wr_valid && !wacc);
      exp_ack = 0;
      exp_nack = 0;
      if (auth_valid) begin
         if (mode0 == M_LOCKED) begin
            if (auth_pass == KEY) begin
               exp_ack = 1;
               m_mode = M_UNL;
               m_fails = 0;
               m_last_act = cyc;
            end else begin
               exp_nack = 1;
               m_fails++;
               if (m_fails == MAX_FAILS) begin
                  m_mode = M_LO;
                  m_lock_start = cyc;
               end
            end
         end else if (mode0 == M_UNL) begin
            exp_ack  = (auth_pass == KEY);
            exp_nack = (auth_pass != KEY);
         end else begin
            exp_nack = 1;
         end
      end
      if (mode0 == M_LO && cyc == m_lock_start + LOCKOUT_CYCLES) begin
         m_mode = M_LOCKED;
         m_fails = 0;
      end
      if (mode0 == M_UNL) begin
         if (lock_req) begin
            m_mode = M_LOCKED;
            relock = 1;
         end else if (racc || wacc) begin
            m_last_act = cyc;
         end else if (cyc == m_last_act + IDLE_TIMEOUT) begin
            m_mode = M_LOCKED;
            relock = 1;
         end
      end
      exp_rdv = 0;
      exp_miss = 0;
      if (racc) begin
         exp_rdv = m_valid[ra];
         exp_miss = !m_valid[ra];
         exp_rd_data = m_valid[ra] ? m_plain[ra] : 8'h00;
      end else if (relock) begin
         exp_rd_data = 8'h00;
      end
      if (wacc) begin
         m_plain[wa] = wr_data;
         m_valid[wa] = 1'b1;
         exp_cipher = wr_data ^ KEY ^ 8'((wa * MUL) % 256);
      end
   endtask

   task automatic check_outputs();
      chk("auth_ack", 32'(auth_ack), 32'(exp_ack));
      chk("auth_nack", 32'(auth_nack), 32'(exp_nack));
      chk("wr_cipher", 32'(wr_cipher), 32'(exp_cipher));
      chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
      chk("rd_data_valid", 32'(rd_data_valid), 32'(exp_rdv));
      chk("rd_miss", 32'(rd_miss), 32'(exp_miss));
      chk("acc_denied", 32'(acc_denied), 32'(exp_denied));
      chk("unlocked", 32'(unlocked), 32'(m_mode == M_UNL));
      chk("locked_out", 32'(locked_out), 32'(m_mode == M_LO));
      chk("fail_count", 32'(fail_count), 32'(m_fails));
   endtask

   task automatic idle_inputs();
      auth_valid = 0; lock_req = 0; wr_valid = 0; rd_valid = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
   endtask

   task automatic do_auth(input logic [7:0] p);
      auth_valid = 1; auth_pass = p;
      tick();
      auth_valid = 0;
   endtask

   task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
      wr_valid = 1; wr_addr = a; wr_data = d;
      tick();
      wr_valid = 0;
   endtask

   task automatic do_rd(input logic [3:0] a);
      rd_valid = 1; rd_addr = a;
      tick();
      rd_valid = 0;
   endtask

   initial begin
      // Reset state and refused access while locked
      apply_reset();
      chk("reset_unlocked", 32'(unlocked), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);
      do_wr(4'd0, 8'h12);
      chk("locked_wr_denied", 32'(acc_denied), 32'd1);
      chk("locked_wr_unlocked", 32'(unlocked), 32'd0);

      // Unlock, encrypt and read back
      do_auth(8'hA5);
      chk("auth_ack", 32'(auth_ack), 32'd1);
      chk("auth_unlocked", 32'(unlocked), 32'd1);
      do_rd(4'd0);
      chk("unwritten_miss", 32'(rd_miss), 32'd1);
      do_wr(4'd0, 8'h12);
      chk("cipher_addr0", 32'(wr_cipher), 32'hB7);
      do_wr(4'd3, 8'h12);
      chk("cipher_addr3", 32'(wr_cipher), 32'hE0);
      do_rd(4'd3);
      chk("read_addr3", 32'(rd_data), 32'h12);
      chk("read_addr3_valid", 32'(rd_data_valid), 32'd1);

      // Read-before-write collision
      do_wr(4'd5, 8'h3A);
      rd_valid = 1; rd_addr = 4'd5; wr_valid = 1; wr_addr = 4'd5; wr_data = 8'h7C;
      tick();
      idle_inputs();
      chk("collision_old", 32'(rd_data), 32'h3A);
      do_rd(4'd5);
      chk("collision_new", 32'(rd_data), 32'h7C);

      // lock_req beats a simultaneous read
      lock_req = 1; rd_valid = 1; rd_addr = 4'd3;
      tick();
      idle_inputs();
      chk("lockreq_denied", 32'(acc_denied), 32'd1);
      chk("lockreq_no_rdv", 32'(rd_data_valid), 32'd0);
      chk("lockreq_rd_cleared", 32'(rd_data), 32'd0);

      // Lockout after three failures
      apply_reset();
      do_auth(8'hFF);
      chk("fail1", 32'(fail_count), 32'd1);
      do_auth(8'hFF);
      chk("fail2", 32'(fail_count), 32'd2);
      do_auth(8'hFF);
      chk("fail3", 32'(fail_count), 32'd3);
      chk("lockout_on", 32'(locked_out), 32'd1);
      do_auth(8'hA5);
      chk("lockout_nack", 32'(auth_nack), 32'd1);
      repeat (62) tick();
      chk("lockout_last", 32'(locked_out), 32'd1);
      tick();
      chk("lockout_off", 32'(locked_out), 32'd0);
      chk("lockout_fail_clr", 32'(fail_count), 32'd0);
      do_auth(8'hA5);
      chk("post_lockout_unlock", 32'(unlocked), 32'd1);

      // Idle relock, then relock deferred by an access at cycle 200
      repeat (255) tick();
      chk("idle_255", 32'(unlocked), 32'd1);
      tick();
      chk("idle_256", 32'(unlocked), 32'd0);
      do_auth(8'hA5);
      repeat (199) tick();
      do_rd(4'd0);
      repeat (255) tick();
      chk("idle_deferred", 32'(unlocked), 32'd1);
      tick();
      chk("idle_deferred_off", 32'(unlocked), 32'd0);

      // Reset while a read is pending
      do_auth(8'hA5);
      do_wr(4'd2, 8'h55);
      do_rd(4'd2);
      chk("pre_reset_read", 32'(rd_data), 32'h55);
      rd_valid = 1; rd_addr = 4'd2;
      #2;
      apply_reset();
      chk("reset_rdv", 32'(rd_data_valid), 32'd0);
      chk("reset_rd_data_clr", 32'(rd_data), 32'd0);
      do_auth(8'hA5);
      do_rd(4'd2);
      chk("reset_map_cleared", 32'(rd_miss), 32'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) apply_reset();
         auth_valid = ($urandom_range(0, 15) == 0);
         auth_pass  = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom);
         lock_req   = ($urandom_range(0, 63) == 0);
         wr_valid   = ($urandom_range(0, 2) == 0);
         wr_addr    = 4'($urandom);
         wr_data    = 8'($urandom);
         rd_valid   = ($urandom_range(0, 2) == 0);
         rd_addr    = 4'($urandom);
         tick();
      end
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
